pwm_multi_burst: RTL and testbench
==================================

# pwm_multi_burst

Parametrised multi-channel PWM generator: CH outputs share one period counter, and each output has its own duty compare value. It runs either continuously or in bursts of a programmed number of periods. Period, duty and burst-length changes are double-buffered through shadow registers, so they take effect only at period boundaries and never glitch an output. It sits between the control register block and the output pins, and supersedes the single-channel PWM for all new designs.

## Interface
- CH, 4: number of PWM channels (1..16).
- CW, 16: width of period, duty and counter, in clock cycles.
- BW, 8: width of burst length.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  1-cycle pulse; begins operation from IDLE.
- stop  in  1  1-cycle pulse; requests a graceful stop.
- mode  in  1  0 = continuous, 1 = burst; sampled on accepted start.
- load  in  1  writes period/duty/burst_len into the shadow registers.
- period  in  CW  period in cycles.
- duty  in  CH*CW  channel i occupies bits [i*CW +: CW]; high time in cycles.
- burst_len  in  BW  number of periods per burst.
- pwm_out  out  CH  PWM outputs, registered.
- period_tick  out  1  1-cycle pulse in the last cycle of each period.
- done  out  1  1-cycle pulse marking the return to IDLE.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States are IDLE, RUN and STOPPING. Reset values: IDLE; cnt = 0; all outputs 0; shadow period = 2, duty = 0, burst_len = 1.
- load = 1 writes shadow_period = max(period, 2), shadow_duty = duty and shadow_burst = burst_len on that edge. Period values 0 and 1 clamp to 2. load is accepted in any state.
- IDLE with start = 1 performs the following on that edge:
  - copy shadow to active (per_q, duty_q, burst_q);
  - set cnt = 0 and latch mode;
  - go to RUN.
- In burst mode with shadow_burst = 0, start is ignored and the block stays in IDLE.
- start is ignored outside IDLE.
- RUN:
  - cnt increments each cycle; at cnt = per_q-1 it wraps to 0.
  - On each wrap, active takes the shadow contents as they stood before that edge. A load in the wrap cycle therefore applies one period later.
  - Burst mode: a period counter counts wraps. When it reaches burst_q, the block goes to IDLE at that wrap instead of restarting.
- stop = 1 in RUN moves to STOPPING. STOPPING continues counting and goes to IDLE at the next wrap. stop in IDLE or STOPPING is ignored.
- If start and stop are both high in IDLE, start wins and stop is ignored.
- pwm_out[i] = (cnt < duty_q[i]) in RUN and STOPPING, and 0 in IDLE.
  - duty_q[i] = 0 gives a constant-low output.
  - duty_q[i] >= per_q gives a constant-high output.
- Comparisons are unsigned, CW bits wide; no arithmetic overflow is possible.
- rst has priority over all other inputs in all states: immediate return to reset values, no done pulse.

## Timing
- start accepted at edge N: cycle N+1 has cnt = 0, busy = 1, and pwm_out reflects cnt = 0. There is 1 cycle of start latency.
- pwm_out is registered, computed from the next cnt and next active values, so it is aligned with cnt in the same cycle.
- period_tick = 1 exactly in cycles where cnt = per_q-1 while busy.
- done = 1 for the single cycle immediately after the final period ends, i.e. the first IDLE cycle. busy = 0 in that same cycle.
- Burst of K periods with period P: busy is high for exactly K*P cycles.
- A start pulse arriving in the done cycle is accepted, giving back-to-back bursts with no gap beyond that cycle.

## Configuration
- PWM_POLARITY_EN defined:
  - adds input pol (CH bits);
  - pwm_out[i] = compare result XOR pol[i];
  - in IDLE and in reset, pwm_out[i] = pol[i].
  - pol is sampled every cycle and is not shadowed.
- Undefined: the pol port is absent and outputs are active-high as described above.

## Test plan
- Continuous mode, CH = 4, period = 10, duty = {0, 3, 10, 12}, start: ch0 constant 0, ch1 high 3 of every 10 cycles, ch2 and ch3 constant 1, period_tick every 10th cycle.
- Burst mode, burst_len = 3, period = 5, duty0 = 2: exactly 3 pulses of 2 cycles, busy high for 15 cycles, done pulse on cycle 16, then outputs 0.
- Mid-period load of period = 8, duty0 = 4 while running at period 10, duty0 = 5: current period completes at 10 / 5, next period is 8 / 4 with no truncated pulse. A load in the wrap cycle applies one period later.
- stop at cnt = 3 of a period-10 run: period finishes, done asserts at the cycle after cnt = 9, further stop pulses are ignored. Burst start with burst_len = 0 is ignored (busy stays 0); period = 0 is loaded as 2.
- rst asserted mid-burst at cnt = 4: next cycle has all outputs 0, busy 0, no done pulse, shadow period 2. With PWM_POLARITY_EN and pol = 4'b1010, idle pwm_out = 4'b1010 and ch1 is inverted while running.

Source files
------------

// File: rtl/pwm_multi_burst.sv
// Multi-channel PWM with a shared period counter, continuous or burst operation, and shadowed period/duty/burst settings.
// Optional per-channel output polarity is enabled by defining PWM_POLARITY_EN.
module pwm_multi_burst #(
  parameter int CH = 4,
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic [BW-1:0]    burst_len,
`ifdef PWM_POLARITY_EN
  input  logic [CH-1:0]    pol,
`endif
  output logic [CH-1:0]    pwm_out,
  output logic             period_tick,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      cnt, cntNext;
  logic [CW-1:0]      perQ, perNext;
  logic [CH*CW-1:0]   dutyQ, dutyNext;
  logic [BW-1:0]      burstQ, burstNext;
  logic               modeQ, modeNext;
  logic [BW-1:0]      wrapCnt, wrapNext;
  logic [CW-1:0]      shPer;
  logic [CH*CW-1:0]   shDuty;
  logic [BW-1:0]      shBurst;
  logic               wrap, lastPeriod, startOk;
  logic               busyNext, tickNext, doneNext;
  logic [CH-1:0]      cmpNext, pwmNext, polVec;

`ifdef PWM_POLARITY_EN
  assign polVec = pol;
`else
  assign polVec = {CH{1'b0}};
`endif

  // Next-state, next-counter and next-active-settings decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    perNext   = perQ;
    dutyNext  = dutyQ;
    burstNext = burstQ;
    modeNext  = modeQ;
    wrapNext  = wrapCnt;
    wrap      = (cnt == (perQ - CW'(1)));
    // The wrap being evaluated is the (wrapCnt+1)-th of this burst
    lastPeriod = modeQ && (({1'b0, wrapCnt} + (BW+1)'(1)) >= {1'b0, burstQ});
    startOk   = start && !(mode && (shBurst == BW'(0)));
    case (state)
      IDLE: begin
        if (startOk) begin
          stateNext = RUN;
          cntNext   = CW'(0);
          perNext   = shPer;
          dutyNext  = shDuty;
          burstNext = shBurst;
          modeNext  = mode;
          wrapNext  = BW'(0);
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        if (wrap) begin
          cntNext = CW'(0);
          if (lastPeriod) begin
            stateNext = IDLE;
          end else begin
            stateNext = stop ? STOPPING : RUN;
            perNext   = shPer;
            dutyNext  = shDuty;
            burstNext = shBurst;
            wrapNext  = wrapCnt + BW'(1);
          end
        end else begin
          cntNext   = cnt + CW'(1);
          stateNext = stop ? STOPPING : RUN;
        end
      end
      STOPPING: begin
        if (wrap) begin
          cntNext   = CW'(0);
          stateNext = IDLE;
        end else begin
          cntNext   = cnt + CW'(1);
          stateNext = STOPPING;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = CW'(0);
      end
    endcase
  end

  // Output decode from next-cycle values so registered outputs line up with cnt
  always_comb begin
    busyNext = (stateNext != IDLE);
    tickNext = busyNext && (cntNext == (perNext - CW'(1)));
    doneNext = (state != IDLE) && (stateNext == IDLE);
    for (int i = 0; i < CH; i++) begin
      cmpNext[i] = (cntNext < dutyNext[i*CW +: CW]);
    end
    pwmNext = ({CH{busyNext}} & cmpNext) ^ polVec;
  end

  // State, counters, active/shadow settings and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= CW'(0);
      perQ        <= CW'(2);
      dutyQ       <= {(CH*CW){1'b0}};
      burstQ      <= BW'(1);
      modeQ       <= 1'b0;
      wrapCnt     <= BW'(0);
      shPer       <= CW'(2);
      shDuty      <= {(CH*CW){1'b0}};
      shBurst     <= BW'(1);
      pwm_out     <= polVec;
      period_tick <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      perQ        <= perNext;
      dutyQ       <= dutyNext;
      burstQ      <= burstNext;
      modeQ       <= modeNext;
      wrapCnt     <= wrapNext;
      pwm_out     <= pwmNext;
      period_tick <= tickNext;
      done        <= doneNext;
      busy        <= busyNext;
      if (load) begin
        shPer   <= (period < CW'(2)) ? CW'(2) : period;
        shDuty  <= duty;
        shBurst <= burst_len;
      end else begin
        shPer   <= shPer;
        shDuty  <= shDuty;
        shBurst <= shBurst;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_burst.sv
// Randomized bench for pwm_multi_burst checked every cycle against a period-level reference model.
module tb_pwm_multi_burst;
  localparam int CH = 4;
  localparam int CW = 16;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, load = 1'b0;
  logic [CW-1:0] period = '0;
  logic [CH*CW-1:0] duty = '0;
  logic [BW-1:0] burst_len = '0;
  logic [CH-1:0] pwm_out;
  logic period_tick, done, busy;
`ifdef PWM_POLARITY_EN
  logic [CH-1:0] pol = 4'b1010;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  // Reference model: phase within the period, active/shadow settings, completed periods
  int mState = 0;  // 0 idle, 1 running, 2 stopping
  int mPos = 0, mPer = 2, mBurst = 1, mWraps = 0;
  int mDuty[CH];
  int sPer = 2, sBurst = 1;
  int sDuty[CH];
  bit mMode = 1'b0;
  bit expDone = 1'b0;

  pwm_multi_burst #(.CH(CH), .CW(CW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .period(period), .duty(duty), .burst_len(burst_len),
`ifdef PWM_POLARITY_EN
    .pol(pol),
`endif
    .pwm_out(pwm_out), .period_tick(period_tick), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic modelReset();
    mState = 0; mPos = 0; mPer = 2; mBurst = 1; mWraps = 0; mMode = 1'b0;
    sPer = 2; sBurst = 1; expDone = 1'b0;
    for (int i = 0; i < CH; i++) begin mDuty[i] = 0; sDuty[i] = 0; end
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared
  task automatic cycle();
    bit wasBusy;
    logic [CH-1:0] expPwm;
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      wasBusy = (mState != 0);
      if (mState == 0) begin
        if (start && !(mode && sBurst == 0)) begin
          mState = 1; mPos = 0; mPer = sPer; mDuty = sDuty; mBurst = sBurst;
          mMode = mode; mWraps = 0;
        end
      end else if (mPos == mPer - 1) begin
        mWraps++;
        mPos = 0;
        if (mState == 2 || (mMode && mWraps >= mBurst)) mState = 0;
        else begin
          mPer = sPer; mDuty = sDuty; mBurst = sBurst;
          if (stop) mState = 2;
        end
      end else begin
        mPos++;
        if (stop && mState == 1) mState = 2;
      end
      expDone = wasBusy && (mState == 0);
      if (load) begin
        sPer = (int'(period) < 2) ? 2 : int'(period);
        for (int i = 0; i < CH; i++) sDuty[i] = int'(duty[i*CW +: CW]);
        sBurst = int'(burst_len);
      end
    end
    #1;
    for (int i = 0; i < CH; i++) expPwm[i] = (mState != 0) && (mPos < mDuty[i]);
`ifdef PWM_POLARITY_EN
    expPwm = expPwm ^ pol;
`endif
    check("pwm_out", 32'(pwm_out), 32'(expPwm));
    check("period_tick", 32'(period_tick), 32'((mState != 0) && (mPos == mPer - 1)));
    check("done", 32'(done), 32'(expDone));
    check("busy", 32'(busy), 32'(mState != 0));
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic doLoad(input int per, input logic [CH*CW-1:0] d, input int bl);
    period = CW'(per); duty = d; burst_len = BW'(bl); load = 1'b1;
    cycle();
  endtask

  task automatic doStart(input bit m);
    mode = m; start = 1'b1;
    cycle();
  endtask

  initial begin
    modelReset();
    rst = 1'b1; cycle();
    rst = 1'b1; cycle();

    // Continuous: ch0 never high, ch1 3 of 10, ch2/ch3 always high
    doLoad(10, {16'd12, 16'd10, 16'd3, 16'd0}, 1);
    doStart(1'b0);
    run(35);

    // Mid-period reload, then a reload in the wrap cycle
    doLoad(8, {16'd12, 16'd10, 16'd3, 16'd4}, 1);
    run(20);
    for (int k = 0; k < 20 && mPos != mPer - 2; k++) cycle();
    cycle();
    doLoad(6, {16'd1, 16'd2, 16'd3, 16'd5}, 1);
    run(20);

    // Graceful stop at cnt 3 of a period-10 run, with repeated stop pulses
    doLoad(10, {16'd9, 16'd1, 16'd3, 16'd5}, 1);
    for (int k = 0; k < 20 && mPos != mPer - 1; k++) cycle();
    run(4);
    stop = 1'b1; cycle();
    stop = 1'b1; cycle();
    run(8);
    stop = 1'b1; cycle();
    run(4);

    // Burst of 3 periods of 5, then back-to-back burst started in the done cycle
    doLoad(5, {16'd0, 16'd0, 16'd5, 16'd2}, 3);
    doStart(1'b1);
    run(15);
    doStart(1'b1);
    run(18);

    // burst_len 0 start ignored; period 0 clamps to 2
    doLoad(0, {16'd0, 16'd0, 16'd0, 16'd1}, 0);
    doStart(1'b1);
    run(4);
    doStart(1'b0);
    run(6);
    stop = 1'b1; cycle();
    run(4);

    // Reset mid-burst at cnt 4
    doLoad(10, {16'd2, 16'd4, 16'd6, 16'd8}, 3);
    doStart(1'b1);
    run(4);
    rst = 1'b1; cycle();
    run(3);
    doStart(1'b0);
    run(5);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      mode  = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 11) == 0);
      period = CW'($urandom_range(0, 12));
      for (int i = 0; i < CH; i++) duty[i*CW +: CW] = CW'($urandom_range(0, 14));
      burst_len = BW'($urandom_range(0, 4));
      cycle();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
